sa_core_arbiter: RTL and testbench
==================================

SA_CORE_ARBITER -- requirements
Module: sa_core_arbiter

Interface
REQ-001 Param NUM_REQ, 4, number of requesters sharing one SA_core.
REQ-002 Param N, 3, matrix dimension; WIDTH, 8, operand bits; ACC, 32, result bits.
REQ-003 Param DRAIN_CYC, 2*N, cycles waited after sa_done before capturing results.
REQ-004 Param TIMEOUT_CYC, 64, watchdog limit in WAIT.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  NUM_REQ  per-requester job request, level.
REQ-008 a_in, b_in  in  [NUM_REQ][N][N] signed WIDTH  per-requester operand matrices.
REQ-009 gnt  out  NUM_REQ  one-hot grant, high for the whole job.
REQ-010 sa_a, sa_b  out  [N][N] signed WIDTH  operands to SA_core A_mem/B_mem.
REQ-011 sa_start  out  1  one-cycle start pulse to SA_core.
REQ-012 sa_done  in  1  SA_core done.
REQ-013 sa_c  in  [N][N] signed ACC  SA_core C_out.
REQ-014 c_out  out  [N][N] signed ACC  captured result; rsp_valid  out  NUM_REQ  one-hot pulse; err  out  1  timeout flag with rsp_valid; busy  out  1  state != IDLE.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT, DRAIN, RESP.
REQ-016 IDLE: when any req high, next edge -> LAUNCH; gnt set to winner; sa_a/sa_b latched from winner's a_in/b_in.
REQ-017 Winner chosen round-robin: first req at or after pointer, wrapping; pointer reset 0, set to winner+1 mod NUM_REQ on entering RESP.
REQ-018 LAUNCH: sa_start=1 exactly one cycle; next edge -> WAIT.
REQ-019 WAIT: sa_done high -> DRAIN with drain counter loaded 0; sa_done outside WAIT ignored.
REQ-020 DRAIN: counter increments; on count DRAIN_CYC-1, c_out <= sa_c, -> RESP.
REQ-021 RESP: rsp_valid[winner]=1, err as set, one cycle; gnt cleared on exit; -> IDLE.
REQ-022 Latency req-to-sa_start = 1 cycle from IDLE; sa_done-to-rsp_valid = DRAIN_CYC+1 cycles.
REQ-023 sa_a/sa_b held stable from LAUNCH until RESP exit; a_in/b_in changes during job ignored.
REQ-024 Requester dropping req after grant: job completes, rsp_valid still issued.
REQ-025 Minimum one IDLE cycle between jobs; requester holding req after rsp_valid re-competes.
REQ-026 c_out holds last captured value until next capture.

Reset
REQ-027 rst asserted: state IDLE, gnt=0, sa_start=0, rsp_valid=0, err=0, busy=0, c_out/sa_a/sa_b=0, pointer=0, counters=0, immediately.
REQ-028 Reset mid-job discards the job; no rsp_valid; requester must re-request.

Configuration
REQ-029 Macro SA_ARB_TIMEOUT_EN defined: WAIT counter; TIMEOUT_CYC cycles without sa_done -> RESP with err=1, c_out=0.
REQ-030 Macro undefined: no watchdog, WAIT indefinite, err tied 0; port list unchanged.

Structure
REQ-031 Package sa_pkg: N, WIDTH, ACC defaults, state enum, operand/result matrix typedefs.
REQ-032 One sub-module rr_arbiter: combinational round-robin pick from req and pointer, outputs one-hot and index.

Verification
REQ-033 Single req[0], identity A, B all 2 -> sa_start 1 cycle after req; rsp_valid[0] DRAIN_CYC+1 after sa_done; c_out all 2.
REQ-034 req=4'b1111 held -> grant order 0,1,2,3,0; each rsp_valid one-hot matching gnt.
REQ-035 req[2] dropped in WAIT -> rsp_valid[2] still pulses, result correct.
REQ-036 rst pulsed during DRAIN -> all outputs 0 next sample, no rsp_valid, pointer 0.
REQ-037 SA_ARB_TIMEOUT_EN, sa_done never asserted -> rsp_valid with err=1 after TIMEOUT_CYC cycles in WAIT, c_out 0.
REQ-038 Random A/B in [-4,4], 10 jobs across requesters -> c_out equals A*B reference per job.

Source files
------------

// File: rtl/sa_core_arbiter_pkg.sv
// Shared types and defaults for the SA_core arbiter slice.
// Optional feature macro: SA_ARB_TIMEOUT_EN (WAIT watchdog).
package sa_pkg;
  localparam int NUM_REQ     = 4;
  localparam int N           = 3;
  localparam int WIDTH       = 8;
  localparam int ACC         = 32;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef logic signed [WIDTH-1:0] opnd_t;
  typedef opnd_t [N-1:0][N-1:0]    opnd_mat_t;
  typedef logic signed [ACC-1:0]   acc_t;
  typedef acc_t [N-1:0][N-1:0]     acc_mat_t;
endpackage

// File: rtl/sa_core_arbiter_if.sv
// Requester-side and SA_core-side signals of the arbiter, bundled.
// slave = arbiter view, master = environment (requesters + SA_core) view.
interface sa_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int N       = 3,
  parameter int WIDTH   = 8,
  parameter int ACC     = 32
);
  logic [NUM_REQ-1:0]                          req;
  logic [NUM_REQ-1:0][N-1:0][N-1:0][WIDTH-1:0] a_in;
  logic [NUM_REQ-1:0][N-1:0][N-1:0][WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]                          gnt;
  logic [N-1:0][N-1:0][WIDTH-1:0]              sa_a;
  logic [N-1:0][N-1:0][WIDTH-1:0]              sa_b;
  logic                                        sa_start;
  logic                                        sa_done;
  logic [N-1:0][N-1:0][ACC-1:0]                sa_c;
  logic [N-1:0][N-1:0][ACC-1:0]                c_out;
  logic [NUM_REQ-1:0]                          rsp_valid;
  logic                                        err;
  logic                                        busy;

  modport slave (
    input  req, a_in, b_in, sa_done, sa_c,
    output gnt, sa_a, sa_b, sa_start, c_out, rsp_valid, err, busy
  );

  modport master (
    output req, a_in, b_in, sa_done, sa_c,
    input  gnt, sa_a, sa_b, sa_start, c_out, rsp_valid, err, busy
  );
endinterface

// File: rtl/sa_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);
  logic [IDX_W-1:0] cand;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sa_core_arbiter.sv
// Shares one SA_core between NUM_REQ requesters, one job at a time.
// Optional: define SA_ARB_TIMEOUT_EN to enable the WAIT watchdog (err on expiry).
//
// state  | meaning
// IDLE   | no job; winner picked and operands latched on any req
// LAUNCH | sa_start pulse to SA_core
// WAIT   | waiting for sa_done (watchdog runs when enabled)
// DRAIN  | DRAIN_CYC cycles for the array to flush, then capture sa_c
// RESP   | rsp_valid to winner for one cycle, grant released
module sa_core_arbiter #(
  parameter int NUM_REQ     = sa_pkg::NUM_REQ,
  parameter int N           = sa_pkg::N,
  parameter int WIDTH       = sa_pkg::WIDTH,
  parameter int ACC         = sa_pkg::ACC,
  parameter int DRAIN_CYC   = 2 * N,
  parameter int TIMEOUT_CYC = sa_pkg::TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  sa_core_arbiter_if.slave   bus
);
  import sa_pkg::*;

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > DRAIN_CYC) ? TIMEOUT_CYC : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                         state_q, state_d;
  logic [NUM_REQ-1:0]             gnt_q;
  logic [IDX_W-1:0]               idx_q;
  logic [IDX_W-1:0]               ptr_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [N-1:0][N-1:0][WIDTH-1:0] sa_a_q, sa_b_q;
  logic [N-1:0][N-1:0][ACC-1:0]   c_out_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               drain_last;
  logic               enter_resp;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign drain_last = (cnt_q == CNT_W'(DRAIN_CYC - 1));
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

`ifdef SA_ARB_TIMEOUT_EN
  logic err_q;
  logic wait_expired;
  assign wait_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.sa_done) state_d = ST_DRAIN;
`ifdef SA_ARB_TIMEOUT_EN
        else if (wait_expired) state_d = ST_RESP;
`endif
      end
      ST_DRAIN:  if (drain_last) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Job datapath: grant, operand latch, counters, result capture, RR pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sa_a_q  <= '0;
      sa_b_q  <= '0;
      c_out_q <= '0;
`ifdef SA_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q  <= arb_gnt;
            idx_q  <= arb_idx;
            sa_a_q <= bus.a_in[arb_idx];
            sa_b_q <= bus.b_in[arb_idx];
            cnt_q  <= '0;
`ifdef SA_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
          end
        end
        ST_WAIT: begin
          if (bus.sa_done) cnt_q <= '0;
`ifdef SA_ARB_TIMEOUT_EN
          else if (wait_expired) begin
            err_q   <= 1'b1;
            c_out_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
`endif
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + 1'b1;
          if (drain_last) c_out_q <= bus.sa_c;
        end
        ST_RESP: gnt_q <= '0;
        default: ;
      endcase
      if (enter_resp) ptr_q <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // State-decoded outputs.
  always_comb begin
    bus.sa_start  = 1'b0;
    bus.rsp_valid = '0;
    bus.err       = 1'b0;
    bus.busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_LAUNCH: bus.sa_start = 1'b1;
      ST_RESP: begin
        bus.rsp_valid = gnt_q;
`ifdef SA_ARB_TIMEOUT_EN
        bus.err       = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.sa_a  = sa_a_q;
  assign bus.sa_b  = sa_b_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_sa_core_arbiter.sv
// Bench for sa_core_arbiter: the bench plays requesters and SA_core, and
// predicts winner order and results from a matrix/round-robin model.
module tb_sa_core_arbiter;
  import sa_pkg::*;

  localparam int DRAIN = 2 * N;
  localparam int TMO   = TIMEOUT_CYC;

  typedef logic [N-1:0][N-1:0][WIDTH-1:0] opv_t;
  typedef logic [N-1:0][N-1:0][ACC-1:0]   resv_t;

  logic clk, rst;

  sa_core_arbiter_if #(.NUM_REQ(NUM_REQ), .N(N), .WIDTH(WIDTH), .ACC(ACC)) bus ();

  sa_core_arbiter #(
    .NUM_REQ(NUM_REQ), .N(N), .WIDTH(WIDTH), .ACC(ACC),
    .DRAIN_CYC(DRAIN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  int                 a_m [NUM_REQ][N][N];
  int                 b_m [NUM_REQ][N][N];
  logic [NUM_REQ-1:0] req_m;
  int                 ptr_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  function automatic int model_pick();
    for (int i = 0; i < NUM_REQ; i++) begin
      int r;
      r = (ptr_m + i) % NUM_REQ;
      if (req_m[r]) return r;
    end
    return 0;
  endfunction

  function automatic opv_t exp_a(input int r);
    opv_t v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) v[i][j] = WIDTH'(a_m[r][i][j]);
    return v;
  endfunction

  function automatic opv_t exp_b(input int r);
    opv_t v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) v[i][j] = WIDTH'(b_m[r][i][j]);
    return v;
  endfunction

  function automatic resv_t ref_prod(input int r);
    resv_t v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += a_m[r][i][k] * b_m[r][k][j];
        v[i][j] = ACC'(s);
      end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ops();
    for (int r = 0; r < NUM_REQ; r++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          bus.a_in[r][i][j] = WIDTH'(a_m[r][i][j]);
          bus.b_in[r][i][j] = WIDTH'(b_m[r][i][j]);
        end
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NUM_REQ; r++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_m[r][i][j] = int'($urandom_range(0, 8)) - 4;
          b_m[r][i][j] = int'($urandom_range(0, 8)) - 4;
        end
    load_ops();
  endtask

  // One full job, starting at a falling edge in IDLE with bus.req = req_m.
  task automatic run_job(input int done_delay, input bit drop);
    int    w, cyc;
    resv_t prod;
    w    = model_pick();
    prod = ref_prod(w);
    tick();
    vecs++; if (bus.sa_start !== 1'b1) begin errs++; $display("FAIL start_latency: got %b want 1", bus.sa_start); end
    vecs++; if (bus.gnt !== (NUM_REQ'(1) << w)) begin errs++; $display("FAIL gnt_launch: got %b want %b", bus.gnt, NUM_REQ'(1) << w); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL busy_launch: got %b want 1", bus.busy); end
    vecs++; if (bus.sa_a !== exp_a(w) || bus.sa_b !== exp_b(w)) begin errs++; $display("FAIL operands_latched: got a=%h b=%h want a=%h b=%h", bus.sa_a, bus.sa_b, exp_a(w), exp_b(w)); end
    tick();
    vecs++; if (bus.sa_start !== 1'b0) begin errs++; $display("FAIL start_width: got %b want 0", bus.sa_start); end
    for (int r = 0; r < NUM_REQ; r++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          bus.a_in[r][i][j] = WIDTH'($urandom);
          bus.b_in[r][i][j] = WIDTH'($urandom);
        end
    if (drop) begin
      req_m[w] = 1'b0;
      bus.req  = req_m;
    end
    repeat (done_delay) tick();
    bus.sa_done = 1'b1;
    bus.sa_c    = prod;
    cyc = 0;
    do begin
      tick();
      cyc++;
      bus.sa_done = 1'b0;
    end while (bus.rsp_valid == '0 && cyc < DRAIN + 20);
    vecs++; if (cyc != DRAIN + 1) begin errs++; $display("FAIL done_to_rsp: got %0d cycles want %0d", cyc, DRAIN + 1); end
    vecs++; if (bus.rsp_valid !== (NUM_REQ'(1) << w)) begin errs++; $display("FAIL rsp_onehot: got %b want %b", bus.rsp_valid, NUM_REQ'(1) << w); end
    vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL err_normal: got %b want 0", bus.err); end
    vecs++; if (bus.c_out !== prod) begin errs++; $display("FAIL c_out_result: got %h want %h", bus.c_out, prod); end
    vecs++; if (bus.sa_a !== exp_a(w) || bus.gnt !== (NUM_REQ'(1) << w)) begin errs++; $display("FAIL held_during_job: got a=%h gnt=%b want a=%h gnt=%b", bus.sa_a, bus.gnt, exp_a(w), NUM_REQ'(1) << w); end
    ptr_m = (w + 1) % NUM_REQ;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) bus.sa_c[i][j] = $urandom;
    tick();
    vecs++; if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.rsp_valid !== '0) begin errs++; $display("FAIL idle_after_resp: got busy=%b gnt=%b rsp=%b want 0 0 0", bus.busy, bus.gnt, bus.rsp_valid); end
    vecs++; if (bus.c_out !== prod) begin errs++; $display("FAIL c_out_hold: got %h want %h", bus.c_out, prod); end
    load_ops();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_m       = '0;
    ptr_m       = 0;
    bus.req     = '0;
    bus.a_in    = '0;
    bus.b_in    = '0;
    bus.sa_done = 1'b0;
    bus.sa_c    = '0;
    @(negedge clk);
    vecs++; if (bus.gnt !== '0 || bus.rsp_valid !== '0) begin errs++; $display("FAIL reset_gnt_rsp: got gnt=%b rsp=%b want 0 0", bus.gnt, bus.rsp_valid); end
    vecs++; if (bus.sa_start !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL reset_ctrl: got start=%b err=%b busy=%b want 0 0 0", bus.sa_start, bus.err, bus.busy); end
    vecs++; if (bus.c_out !== '0 || bus.sa_a !== '0 || bus.sa_b !== '0) begin errs++; $display("FAIL reset_data: got c_out=%h sa_a=%h sa_b=%h want 0", bus.c_out, bus.sa_a, bus.sa_b); end
    rst = 1'b0;
    tick();
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL idle_no_req: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_single();
    resv_t twos;
    for (int r = 0; r < NUM_REQ; r++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_m[r][i][j] = (r == 0) ? ((i == j) ? 1 : 0) : 0;
          b_m[r][i][j] = (r == 0) ? 2 : 0;
        end
    load_ops();
    bus.sa_done = 1'b1;
    tick();
    bus.sa_done = 1'b0;
    tick();
    vecs++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin errs++; $display("FAIL done_in_idle: got busy=%b rsp=%b want 0 0", bus.busy, bus.rsp_valid); end
    req_m   = 4'b0001;
    bus.req = req_m;
    run_job(2, 1'b0);
    req_m   = '0;
    bus.req = req_m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) twos[i][j] = ACC'(2);
    vecs++; if (bus.c_out !== twos) begin errs++; $display("FAIL identity_times_twos: got %h want %h", bus.c_out, twos); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    ptr_m = 0;
    req_m   = 4'b1111;
    bus.req = req_m;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      run_job(int'($urandom_range(0, 3)), 1'b0);
    end
    req_m   = '0;
    bus.req = req_m;
    tick();
  endtask

  task automatic test_drop();
    rand_ops();
    req_m   = 4'b0100;
    bus.req = req_m;
    run_job(3, 1'b1);
    tick();
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL dropped_no_rerun: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_drain();
    bit seen;
    rand_ops();
    req_m   = 4'b0010;
    bus.req = req_m;
    tick();
    tick();
    bus.sa_done = 1'b1;
    bus.sa_c    = ref_prod(1);
    tick();
    bus.sa_done = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vecs++; if (bus.gnt !== '0 || bus.sa_start !== 1'b0 || bus.rsp_valid !== '0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL reset_drain_ctrl: got gnt=%b start=%b rsp=%b err=%b busy=%b want all 0", bus.gnt, bus.sa_start, bus.rsp_valid, bus.err, bus.busy); end
    vecs++; if (bus.c_out !== '0 || bus.sa_a !== '0 || bus.sa_b !== '0) begin errs++; $display("FAIL reset_drain_data: got c_out=%h sa_a=%h want 0", bus.c_out, bus.sa_a); end
    ptr_m   = 0;
    req_m   = '0;
    bus.req = req_m;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < DRAIN + 4; k++) begin
      tick();
      if (bus.rsp_valid != '0 || bus.busy) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL reset_discards_job: got activity=%b want 0", seen); end
    rand_ops();
    req_m   = 4'b1111;
    bus.req = req_m;
    run_job(1, 1'b0);
    req_m   = '0;
    bus.req = req_m;
  endtask

  task automatic test_timeout();
    int    w, cyc;
    resv_t prod;
    rand_ops();
    req_m   = 4'b0001;
    bus.req = req_m;
    w       = model_pick();
    prod    = ref_prod(w);
    tick();
    req_m   = '0;
    bus.req = req_m;
    vecs++; if (bus.sa_start !== 1'b1) begin errs++; $display("FAIL timeout_start: got %b want 1", bus.sa_start); end
`ifdef SA_ARB_TIMEOUT_EN
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.rsp_valid == '0 && cyc < TMO + 20);
    vecs++; if (cyc != TMO + 1) begin errs++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, TMO + 1); end
    vecs++; if (bus.rsp_valid !== (NUM_REQ'(1) << w) || bus.err !== 1'b1) begin errs++; $display("FAIL timeout_rsp: got rsp=%b err=%b want %b 1", bus.rsp_valid, bus.err, NUM_REQ'(1) << w); end
    vecs++; if (bus.c_out !== '0) begin errs++; $display("FAIL timeout_c_out: got %h want 0", bus.c_out); end
    ptr_m = (w + 1) % NUM_REQ;
    tick();
    vecs++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL timeout_exit: got err=%b busy=%b want 0 0", bus.err, bus.busy); end
`else
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < TMO + 40; k++) begin
        tick();
        if (bus.rsp_valid != '0 || bus.err) seen = 1'b1;
      end
      vecs++; if (seen !== 1'b0 || bus.busy !== 1'b1) begin errs++; $display("FAIL wait_indefinite: got early_rsp=%b busy=%b want 0 1", seen, bus.busy); end
      bus.sa_done = 1'b1;
      bus.sa_c    = prod;
      cyc = 0;
      do begin
        tick();
        cyc++;
        bus.sa_done = 1'b0;
      end while (bus.rsp_valid == '0 && cyc < DRAIN + 20);
      vecs++; if (bus.rsp_valid !== (NUM_REQ'(1) << w) || bus.err !== 1'b0) begin errs++; $display("FAIL late_done_rsp: got rsp=%b err=%b want %b 0", bus.rsp_valid, bus.err, NUM_REQ'(1) << w); end
      vecs++; if (bus.c_out !== prod) begin errs++; $display("FAIL late_done_c_out: got %h want %h", bus.c_out, prod); end
      ptr_m = (w + 1) % NUM_REQ;
      tick();
    end
`endif
  endtask

  task automatic test_random_jobs();
    for (int k = 0; k < 10; k++) begin
      req_m   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      bus.req = req_m;
      rand_ops();
      run_job(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end
    req_m   = '0;
    bus.req = req_m;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_drain();
    test_timeout();
    test_random_jobs();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
